// File: rtl/sc_mmio_pkg.sv
// Shared definitions for the MMIO controller: register map, reset values
// and the 7-segment glyph table.
package sc_mmio_pkg;

   // Word offsets decoded from addr[4:2]
   typedef enum logic [2:0] {
      REG_SW    = 3'd0,
      REG_LED   = 3'd1,
      REG_HEX   = 3'd2,
      REG_BLANK = 3'd3,
      REG_CHG   = 3'd4,
      REG_IE    = 3'd5,
      REG_RSV6  = 3'd6,
      REG_RSV7  = 3'd7
   } reg_off_e;

   localparam logic       IE_RST   = 1'b0;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // Nibble to active-low gfedcba segments
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sc_mmio_ctrl_sw_debounce.sv
// One switch bit: 2-FF synchroniser, stability counter and debounced output.
// chg pulses in the cycle whose clock edge updates sw_deb.
module sc_sw_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_deb,
   output logic chg
);

   localparam int            CW       = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          mismatch;

   // Accept the new value once the mismatch has lasted DEB_CYCLES samples
   always_comb begin
      mismatch = (sync2 != sw_deb);
      chg      = mismatch && (cnt == CNT_LAST);
   end

   // Synchroniser, counter and debounced state
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         sw_deb <= 1'b0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         if (!mismatch) begin
            cnt <= '0;
         end else if (chg) begin
            cnt    <= '0;
            sw_deb <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_mmio_ctrl.sv
// Memory-mapped switch/LED/hex controller with debounced switches,
// registered read-back, hex blanking and a sticky switch-change interrupt.
module sc_mmio_ctrl
   import sc_mmio_pkg::*;
#(
   parameter int SW_W       = 10,
   parameter int LED_W      = 10,
   parameter int HEX_DIGITS = 6,
   parameter int DEB_CYCLES = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    sel,
   input  logic [31:0]             addr,
   input  logic                    we,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata,
   output logic                    irq,
   input  logic [SW_W-1:0]         io_in_sw,
   output logic [LED_W-1:0]        io_out_led,
   output logic [7*HEX_DIGITS-1:0] io_out_hex
);

   reg_off_e                  off;
   logic                      wr;
   logic [SW_W-1:0]           sw_deb;
   logic [SW_W-1:0]           chg_set;
   logic [SW_W-1:0]           chg_clr;
   logic [LED_W-1:0]          led_q;
   logic [4*HEX_DIGITS-1:0]   hex_q;
   logic [HEX_DIGITS-1:0]     blank_q;
   logic [SW_W-1:0]           chg_q;
   logic                      ie_q;
   logic [31:0]               rd_val;
   logic                      unused_bus_bits;

   assign off             = reg_off_e'(addr[4:2]);
   assign wr              = sel && we;
   assign unused_bus_bits = ^{addr[31:5], addr[1:0], wdata};

   for (genvar i = 0; i < SW_W; i++) begin : g_sw
      sc_sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clock  (clock),
         .reset  (reset),
         .sw_raw (io_in_sw[i]),
         .sw_deb (sw_deb[i]),
         .chg    (chg_set[i])
      );
   end

   // W1C mask for the change register
   always_comb begin
      chg_clr = '0;
      if (wr && off == REG_CHG) chg_clr = wdata[SW_W-1:0];
   end

   // Writable registers; a change event beats a same-cycle clear
   always_ff @(posedge clock) begin
      if (reset) begin
         led_q   <= '0;
         hex_q   <= '0;
         blank_q <= '1;
         chg_q   <= '0;
         ie_q    <= IE_RST;
      end else begin
         if (wr && off == REG_LED)   led_q   <= wdata[LED_W-1:0];
         if (wr && off == REG_HEX)   hex_q   <= wdata[4*HEX_DIGITS-1:0];
         if (wr && off == REG_BLANK) blank_q <= wdata[HEX_DIGITS-1:0];
         if (wr && off == REG_IE)    ie_q    <= wdata[0];
         chg_q <= (chg_q & ~chg_clr) | chg_set;
      end
   end

   // Read mux, zero-extended
   always_comb begin
      rd_val = '0;
      case (off)
         REG_SW:    rd_val[SW_W-1:0]         = sw_deb;
         REG_LED:   rd_val[LED_W-1:0]        = led_q;
         REG_HEX:   rd_val[4*HEX_DIGITS-1:0] = hex_q;
         REG_BLANK: rd_val[HEX_DIGITS-1:0]   = blank_q;
         REG_CHG:   rd_val[SW_W-1:0]         = chg_q;
         REG_IE:    rd_val[0]                = ie_q;
         default:   rd_val                   = '0;
      endcase
   end

   // Registered read data, zero when not selected
   always_ff @(posedge clock) begin
      if (reset) rdata <= '0;
      else       rdata <= sel ? rd_val : '0;
   end

   // Hex decode with per-digit blanking
   always_comb begin
      io_out_hex = '1;
      for (int unsigned k = 0; k < HEX_DIGITS; k++) begin
         if (!blank_q[k]) io_out_hex[7*k +: 7] = seg7(hex_q[4*k +: 4]);
         else             io_out_hex[7*k +: 7] = SEG_OFF;
      end
   end

   // Interrupt and LED drive straight from registers
   always_comb begin
      irq        = ie_q && (|chg_q);
      io_out_led = led_q;
   end

endmodule

// File: tb/tb_sc_mmio_ctrl.sv
// Directed bench for sc_mmio_ctrl: bus reads push expected data into a
// scoreboard queue; a monitor pops and compares one cycle after each read.
module tb_sc_mmio_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        sel;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [9:0]  io_in_sw;
   logic [9:0]  io_out_led;
   logic [41:0] io_out_hex;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   logic rd_seen = 1'b0;

   always #5 clock = ~clock;

   sc_mmio_ctrl #(
      .SW_W       (10),
      .LED_W      (10),
      .HEX_DIGITS (6),
      .DEB_CYCLES (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sel        (sel),
      .addr       (addr),
      .we         (we),
      .wdata      (wdata),
      .rdata      (rdata),
      .irq        (irq),
      .io_in_sw   (io_in_sw),
      .io_out_led (io_out_led),
      .io_out_hex (io_out_hex)
   );

   // Note which edges carried a read access
   always @(posedge clock) rd_seen <= sel && !we && !reset;

   // Scoreboard monitor: rdata is valid one cycle after the access
   always @(negedge clock) begin
      exp_t e;
      if (rd_seen) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read rdata=%h required=<none queued>", rdata);
         end else begin
            e = sb_q.pop_front();
            if (rdata !== e.exp) begin
               n_fail++;
               $display("FAIL %s rdata=%h required=%h", e.name, rdata, e.exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Bus tasks are entered at a falling edge and return at the next one
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      sel = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(posedge clock);
      @(negedge clock);
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
      exp_t t;
      t.name = nm;
      t.exp  = e;
      sb_q.push_back(t);
      sel = 1'b1; we = 1'b0; addr = a;
      @(posedge clock);
      @(negedge clock);
      sel = 1'b0;
   endtask

   // Read SW every cycle after reset release; debounce completes on edge 18
   task automatic sw_ramp(input string nm);
      for (int i = 1; i <= 20; i++)
         bus_read(32'h0, (i >= 19) ? 32'h3FF : 32'h0, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout n_checks=%0d required=<finish>", n_checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      io_in_sw = 10'h3FF;
      repeat (3) @(negedge clock);
      chk("rst_led",   64'(io_out_led), 64'h0);
      chk("rst_hex",   64'(io_out_hex), 64'h3FF_FFFF_FFFF);
      chk("rst_irq",   64'(irq),        64'h0);
      chk("rst_rdata", 64'(rdata),      64'h0);
      reset = 1'b0;
      sw_ramp("sw_after_reset");
      bus_read(32'h10, 32'h3FF, "chg_after_reset");
      bus_read(32'h14, 32'h0,   "ie_reset");
      bus_write(32'h10, 32'h3FF);
      bus_read(32'h10, 32'h0,   "chg_cleared");
      chk("irq_ie0", 64'(irq), 64'h0);

      // LED
      bus_write(32'h04, 32'hFFFF_FFFF);
      chk("led_all", 64'(io_out_led), 64'h3FF);
      bus_read(32'h04, 32'h3FF, "led_read");
      bus_write(32'h04, 32'h155);
      chk("led_155", 64'(io_out_led), 64'h155);

      // HEX and BLANK
      bus_write(32'h08, 32'h0012_3456);
      bus_write(32'h0C, 32'h0);
      chk("hex_123456", 64'(io_out_hex),
          64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
      bus_write(32'h0C, 32'h21);
      chk("hex_blank21", 64'(io_out_hex),
          64'({7'h7F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h7F}));
      bus_read(32'h08, 32'h0012_3456, "hex_read");
      bus_read(32'h0C, 32'h21,        "blank_read");
      bus_write(32'h08, 32'hFFFE_DCBA);
      bus_read(32'h08, 32'h00FE_DCBA, "hex_trunc");
      chk("hex_fedcba_b21", 64'(io_out_hex),
          64'({7'h7F, 7'h06, 7'h21, 7'h46, 7'h03, 7'h7F}));
      bus_write(32'h0C, 32'hFFFF_FFC0);
      bus_read(32'h0C, 32'h0, "blank_trunc");
      chk("hex_fedcba", 64'(io_out_hex),
          64'({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08}));

      // Switch debounce: clean fall of bit 3
      io_in_sw = 10'h3F7;
      repeat (25) @(negedge clock);
      bus_read(32'h00, 32'h3F7, "sw3_fall");
      bus_read(32'h10, 32'h008, "chg3_fall");
      bus_write(32'h10, 32'h008);
      bus_read(32'h10, 32'h0,   "chg3_clr");
      // 10-cycle glitch is rejected
      io_in_sw = 10'h3FF;
      repeat (10) @(negedge clock);
      io_in_sw = 10'h3F7;
      repeat (25) @(negedge clock);
      bus_read(32'h00, 32'h3F7, "sw_glitch");
      bus_read(32'h10, 32'h0,   "chg_glitch");
      // Stable rise accepted
      io_in_sw = 10'h3FF;
      repeat (25) @(negedge clock);
      bus_read(32'h00, 32'h3FF, "sw3_rise");
      bus_read(32'h10, 32'h008, "chg3_rise");
      chk("irq_ie_off", 64'(irq), 64'h0);
      bus_write(32'h14, 32'h1);
      chk("irq_on", 64'(irq), 64'h1);
      bus_read(32'h14, 32'h1, "ie_read");

      // Clear collides with the debounced fall on edge 18: set wins
      bus_write(32'h10, 32'h3FF);
      chk("irq_cleared", 64'(irq), 64'h0);
      io_in_sw = 10'h3F7;
      repeat (17) @(negedge clock);
      bus_write(32'h10, 32'h008);
      bus_read(32'h10, 32'h008, "chg_set_wins");
      chk("irq_set_wins", 64'(irq), 64'h1);
      bus_write(32'h10, 32'h008);
      chk("irq_w1c", 64'(irq), 64'h0);
      bus_read(32'h10, 32'h0, "chg_w1c");

      // Reserved offsets
      bus_read(32'h18, 32'h0, "rsv6_read");
      bus_write(32'h1C, 32'hFFFF_FFFF);
      bus_write(32'h18, 32'hFFFF_FFFF);
      bus_read(32'h1C, 32'h0,         "rsv7_read");
      bus_read(32'h04, 32'h155,       "led_kept");
      bus_read(32'h08, 32'h00FE_DCBA, "hex_kept");
      bus_read(32'h0C, 32'h0,         "blank_kept");
      bus_read(32'h14, 32'h1,         "ie_kept");
      bus_read(32'h10, 32'h0,         "chg_kept");
      @(negedge clock);
      chk("rdata_idle", 64'(rdata), 64'h0);

      // Reset in the middle of a debounce count
      io_in_sw = 10'h3FF;
      repeat (10) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst2_led", 64'(io_out_led), 64'h0);
      chk("rst2_hex", 64'(io_out_hex), 64'h3FF_FFFF_FFFF);
      chk("rst2_irq", 64'(irq),        64'h0);
      reset = 1'b0;
      sw_ramp("sw_after_midreset");
      bus_read(32'h10, 32'h3FF, "chg_after_midreset");
      bus_read(32'h0C, 32'h3F,  "blank_reset");
      bus_read(32'h08, 32'h0,   "hex_reset");
      bus_read(32'h14, 32'h0,   "ie_reset2");

      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
